// File: rtl/button_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : button_input_sequencer
// Description : Debounces four active-low pushbuttons, captures switch fields
//               on each press and sequences one instruction into single-cycle
//               execute / clear strobes for the regfile/ALU stage.
// Revision    : 1.0 - initial release
// ============================================================================
module button_input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  data_input,
    input  logic        btn_setup_n,
    input  logic        btn_reg_n,
    input  logic        btn_imm_n,
    input  logic        btn_step_n,
    output logic [7:0]  opcode,
    output logic [3:0]  rdest,
    output logic [3:0]  rsrc,
    output logic [15:0] imm,
    output logic        use_imm,
    output logic        exec_pulse,
    output logic        clear_pulse,
    output logic        err_seq,
    output logic [2:0]  state_dbg
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_OP   = 3'd1;
    localparam logic [2:0] c_S_REGS = 3'd2;
    localparam logic [2:0] c_S_EXEC = 3'd3;

    // Index order: 0=setup, 1=reg, 2=imm, 3=step
    logic [3:0] w_btn_n;
    logic [3:0] w_press;

    assign w_btn_n = {btn_step_n, btn_imm_n, btn_reg_n, btn_setup_n};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic [SYNC_STAGES-1:0] r_sync;
            logic [CNT_W-1:0]       r_cnt;
            logic                   r_level;
            logic                   r_press;
            logic                   w_synced;

            assign w_synced = r_sync[SYNC_STAGES-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync  <= '1;
                    r_cnt   <= '0;
                    r_level <= 1'b1;
                    r_press <= 1'b0;
                end else begin
                    r_sync  <= {r_sync[SYNC_STAGES-2:0], w_btn_n[gi]};
                    r_press <= 1'b0;
                    if (w_synced != r_level) begin
                        if (r_cnt == c_CNT_MAX) begin
                            r_level <= w_synced;
                            r_cnt   <= '0;
                            // Only the falling (pressed) transition is reported
                            r_press <= r_level & ~w_synced;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    logic w_sel_setup;
    logic w_sel_reg;
    logic w_sel_imm;
    logic w_sel_step;
    logic w_unused_bits;

    assign w_sel_setup   = w_press[0];
    assign w_sel_reg     = w_press[1] & ~w_press[0];
    assign w_sel_imm     = w_press[2] & ~(|w_press[1:0]);
    assign w_sel_step    = w_press[3] & ~(|w_press[2:0]);
    assign w_unused_bits = data_input[8];

    logic [2:0]  r_state;
    logic [7:0]  r_opcode;
    logic [3:0]  r_rdest;
    logic [3:0]  r_rsrc;
    logic [15:0] r_imm;
    logic        r_use_imm;
    logic        r_exec;
    logic        r_clear;
    logic        r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_opcode  <= '0;
            r_rdest   <= '0;
            r_rsrc    <= '0;
            r_imm     <= '0;
            r_use_imm <= 1'b0;
            r_exec    <= 1'b0;
            r_clear   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_exec  <= 1'b0;
            r_clear <= 1'b0;
            r_err   <= 1'b0;
            if (r_state == c_S_EXEC) begin
                // Execute cycle swallows any press that lands here
                r_state <= c_S_REGS;
            end else if (w_sel_setup && data_input[9]) begin
                r_clear   <= 1'b1;
                r_opcode  <= '0;
                r_rdest   <= '0;
                r_rsrc    <= '0;
                r_imm     <= '0;
                r_use_imm <= 1'b0;
                r_state   <= c_S_IDLE;
            end else begin
                case (r_state)
                    c_S_IDLE: begin
                        if (w_sel_setup) begin
                            r_opcode <= data_input[7:0];
                            r_state  <= c_S_OP;
                        end else if (w_sel_reg || w_sel_imm || w_sel_step) begin
                            r_err <= 1'b1;
                        end
                    end
                    c_S_OP: begin
                        if (w_sel_setup) begin
                            r_opcode <= data_input[7:0];
                        end else if (w_sel_reg) begin
                            r_rdest   <= data_input[7:4];
                            r_rsrc    <= data_input[3:0];
                            r_use_imm <= 1'b0;
                            r_state   <= c_S_REGS;
                        end else if (w_sel_imm || w_sel_step) begin
                            r_err <= 1'b1;
                        end
                    end
                    c_S_REGS: begin
                        if (w_sel_setup) begin
                            r_opcode <= data_input[7:0];
                            r_state  <= c_S_OP;
                        end else if (w_sel_reg) begin
                            r_rdest   <= data_input[7:4];
                            r_rsrc    <= data_input[3:0];
                            r_use_imm <= 1'b0;
                        end else if (w_sel_imm) begin
                            r_imm     <= {{8{data_input[7]}}, data_input[7:0]};
                            r_use_imm <= 1'b1;
                        end else if (w_sel_step) begin
                            r_exec  <= 1'b1;
                            r_state <= c_S_EXEC;
                        end
                    end
                    default: r_state <= c_S_IDLE;
                endcase
            end
        end
    end

    assign opcode      = r_opcode;
    assign rdest       = r_rdest;
    assign rsrc        = r_rsrc;
    assign imm         = r_imm;
    assign use_imm     = r_use_imm;
    assign exec_pulse  = r_exec;
    assign clear_pulse = r_clear;
    assign err_seq     = r_err;
    assign state_dbg   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_button_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_input_sequencer
// Description : Directed self-checking bench for button_input_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_input_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  data_input = '0;
    logic [3:0]  btn_n = 4'hF;   // 0=setup 1=reg 2=imm 3=step
    logic [7:0]  opcode;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [15:0] imm;
    logic        use_imm;
    logic        exec_pulse;
    logic        clear_pulse;
    logic        err_seq;
    logic [2:0]  state_dbg;

    int n_vec  = 0;
    int n_fail = 0;
    int n_exec = 0;
    int n_clr  = 0;
    int n_err  = 0;
    int e0, c0, r0;

    always #5 clk = ~clk;

    button_input_sequencer #(
        .DEBOUNCE_CYCLES(16),
        .SYNC_STAGES    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_input (data_input),
        .btn_setup_n(btn_n[0]),
        .btn_reg_n  (btn_n[1]),
        .btn_imm_n  (btn_n[2]),
        .btn_step_n (btn_n[3]),
        .opcode     (opcode),
        .rdest      (rdest),
        .rsrc       (rsrc),
        .imm        (imm),
        .use_imm    (use_imm),
        .exec_pulse (exec_pulse),
        .clear_pulse(clear_pulse),
        .err_seq    (err_seq),
        .state_dbg  (state_dbg)
    );

    // Strobe-cycle counters; each edge adds the value held during the cycle it closes
    always @(posedge clk) begin
        n_exec <= n_exec + int'(exec_pulse);
        n_clr  <= n_clr  + int'(clear_pulse);
        n_err  <= n_err  + int'(err_seq);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press at a negedge; 2 sync + 16 debounce + 1 FSM edge later the result is visible
    task automatic press(input logic [3:0] mask, input logic [9:0] d);
        data_input = d;
        btn_n      = ~mask;
        tick(19);
    endtask

    task automatic release_all();
        btn_n = 4'hF;
        tick(20);
    endtask

    initial begin
        // Reset
        tick(3);
        chk("rst_fields", {opcode, rdest, rsrc, imm}, 32'h0);
        chk("rst_flags", {use_imm, exec_pulse, clear_pulse, err_seq, state_dbg}, 32'h0);
        rst = 1'b0;
        e0 = n_exec; c0 = n_clr; r0 = n_err;
        tick(100);
        chk("idle_strobes", (n_exec - e0) + (n_clr - c0) + (n_err - r0), 32'd0);
        chk("idle_state", state_dbg, 32'd0);

        // Short glitch rejected
        data_input = 10'h0AA;
        btn_n[0] = 1'b0;
        tick(10);
        btn_n[0] = 1'b1;
        tick(30);
        chk("glitch_state", state_dbg, 32'd0);
        chk("glitch_opcode", opcode, 32'h0);

        // Exact press latency
        data_input = 10'h025;
        btn_n[0] = 1'b0;
        tick(18);
        chk("lat_early_state", state_dbg, 32'd0);
        tick(1);
        chk("lat_state", state_dbg, 32'd1);
        chk("lat_opcode", opcode, 32'h25);
        tick(21);
        release_all();
        chk("release_state", state_dbg, 32'd1);

        // Full instruction
        press(4'b0001, 10'h004);
        chk("op_opcode", opcode, 32'h04);
        release_all();
        press(4'b0010, 10'h031);
        chk("reg_fields", {rdest, rsrc, 3'b0, use_imm, 1'b0, state_dbg}, {4'h3, 4'h1, 3'b0, 1'b0, 1'b0, 3'd2});
        release_all();
        press(4'b0100, 10'h0F8);
        chk("imm_value", imm, 32'hFFF8);
        chk("imm_use", use_imm, 32'd1);
        release_all();
        e0 = n_exec;
        press(4'b1000, 10'h000);
        chk("exec_early", n_exec - e0, 32'd0);
        chk("exec_high", {exec_pulse, state_dbg}, {1'b1, 3'd3});
        tick(1);
        chk("exec_low", {exec_pulse, state_dbg}, {1'b0, 3'd2});
        release_all();
        chk("exec_once", n_exec - e0, 32'd1);
        chk("exec_fields", {opcode, rdest, rsrc, imm}, {8'h04, 4'h3, 4'h1, 16'hFFF8});
        e0 = n_exec;
        press(4'b1000, 10'h000);
        release_all();
        chk("exec_again", n_exec - e0, 32'd1);
        chk("exec_again_state", state_dbg, 32'd2);

        // Clear from S_REGS
        c0 = n_clr;
        press(4'b0001, 10'h200);
        chk("clr_pulse", clear_pulse, 32'd1);
        chk("clr_fields", {opcode, rdest, rsrc, imm}, 32'h0);
        chk("clr_flags", {use_imm, state_dbg}, 32'h0);
        release_all();
        chk("clr_once", n_clr - c0, 32'd1);

        // Back to S_REGS, then setup+step together
        press(4'b0001, 10'h011);
        release_all();
        press(4'b0010, 10'h052);
        release_all();
        chk("resetup_state", state_dbg, 32'd2);
        e0 = n_exec; r0 = n_err;
        press(4'b1001, 10'h0AB);
        chk("simul_opcode", opcode, 32'hAB);
        chk("simul_state", state_dbg, 32'd1);
        release_all();
        chk("simul_strobes", (n_exec - e0) + (n_err - r0), 32'd0);

        // Reset during S_EXEC
        press(4'b0010, 10'h052);
        release_all();
        press(4'b1000, 10'h000);
        chk("pre_rst_exec", state_dbg, 32'd3);
        rst   = 1'b1;
        btn_n = 4'hF;
        tick(1);
        chk("rst_exec_fields", {opcode, rdest, rsrc, imm}, 32'h0);
        chk("rst_exec_flags", {use_imm, exec_pulse, clear_pulse, err_seq, state_dbg}, 32'h0);
        tick(1);
        rst = 1'b0;
        e0 = n_exec;
        tick(30);
        chk("post_rst_quiet", {n_exec - e0, 29'b0, state_dbg}, 32'h0);

        // Illegal order from reset
        e0 = n_exec; r0 = n_err;
        press(4'b1000, 10'h000);
        chk("err_step", {err_seq, state_dbg}, {1'b1, 3'd0});
        release_all();
        press(4'b0100, 10'h07F);
        chk("err_imm", {err_seq, state_dbg}, {1'b1, 3'd0});
        release_all();
        chk("err_count", n_err - r0, 32'd2);
        chk("err_no_exec", n_exec - e0, 32'd0);
        chk("err_no_imm", {imm, 15'b0, use_imm}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
